// File: rtl/comp_bist.sv
// comp_bist: exhaustive 4-bit comparator self-test; sweeps all 256 A/B pairs
// and records the error count and the first failing pair.
module comp_bist #(
  parameter int SETTLE = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       abort,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       comp_rst,
  input  logic       ag,
  input  logic       bg,
  input  logic       eq,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_cnt,
  output logic [3:0] fail_a,
  output logic [3:0] fail_b
);
  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, SAMPLE, DONE} state_t;
  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);
  state_t     r_state, w_next;
  logic [7:0] r_idx;
  logic [3:0] r_cnt, r_a, r_b, r_fa, r_fb;
  logic [8:0] r_err;
  logic       r_pass;
  logic       w_run, w_abort, w_miss;
  assign w_run   = r_state inside {DRIVE, WAIT, SAMPLE};
  assign w_abort = w_run && abort;
  // any flag off its ideal value, so stuck or non-one-hot flags all count
  assign w_miss  = (ag != (r_a > r_b)) || (bg != (r_b > r_a)) || (eq != (r_a == r_b));
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? DRIVE : IDLE;
      DRIVE:   w_next = (SETTLE == 0) ? SAMPLE : WAIT;
      WAIT:    w_next = (r_cnt == 4'd0) ? SAMPLE : WAIT;
      SAMPLE:  w_next = (r_idx == 8'hff) ? DONE : DRIVE;
      default: w_next = IDLE;
    endcase
    if (w_abort) w_next = IDLE;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_idx  <= '0;
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_fa   <= '0;
      r_fb   <= '0;
      r_err  <= '0;
      r_pass <= 1'b0;
    end else if (w_abort) begin
      r_a    <= '0;
      r_b    <= '0;
      r_pass <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_idx  <= '0;
          r_err  <= '0;
          r_fa   <= '0;
          r_fb   <= '0;
          r_pass <= 1'b0;
        end
        DRIVE: begin
          r_a   <= r_idx[7:4];
          r_b   <= r_idx[3:0];
          r_cnt <= SETTLE_M1;
        end
        WAIT: r_cnt <= r_cnt - 4'd1;
        SAMPLE: begin
          r_idx <= r_idx + 8'd1;
          if (w_miss) begin
            r_err <= r_err + 9'd1;
            if (r_err == 9'd0) begin
              r_fa <= r_a;
              r_fb <= r_b;
            end
          end
        end
        DONE: r_pass <= (r_err == 9'd0);
        default: ;
      endcase
    end
  end
  assign A        = r_a;
  assign B        = r_b;
  assign comp_rst = (r_state != IDLE);
  assign busy     = w_run;
  assign done     = (r_state == DONE);
  assign pass     = r_pass;
  assign err_cnt  = r_err;
  assign fail_a   = r_fa;
  assign fail_b   = r_fb;
endmodule
